// File: rtl/video_address_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : video_address_sequencer
//  Brief    : Viewport video RAM address, byte/row-repeat and alpha-row
//             sequencer driven by line/frame/fetch strobes.
//  Revision : 1.0  initial release
// ============================================================================
module video_address_sequencer #(
  parameter int          ADDR_W       = 13,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int          ACTIVE_LINES = 192,
  parameter int          ALPHA_ROWS   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              fetch,
  input  logic              wide,
  input  logic [1:0]        repeat_sel,
  output logic [ADDR_W-1:0] DA,
  output logic [3:0]        alpha_row,
  output logic              rp,
  output logic              line_done,
  output logic              frame_done,
  output logic              overrun
);

  localparam int              c_lc_w   = $clog2(ACTIVE_LINES + 1);
  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
  localparam logic [c_lc_w-1:0] c_last_line = c_lc_w'(ACTIVE_LINES - 1);
  localparam logic [3:0]        c_last_row  = 4'(ALPHA_ROWS - 1);

  typedef enum logic [1:0] {
    S_WAIT_LINE = 2'd0,
    S_FETCH     = 2'd1,
    S_LINE_END  = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   da_q;
  logic [ADDR_W-1:0]   line_base_q;
  logic [5:0]          byte_cnt_q;
  logic [5:0]          bytes_q;
  logic [3:0]          rep_q;
  logic [3:0]          rep_cnt_q;
  logic [c_lc_w-1:0]   line_cnt_q;
  logic [3:0]          alpha_row_q;
  logic                rp_q;
  logic                line_done_q;
  logic                frame_done_q;
  logic                overrun_q;

  logic [5:0]          bytes_d;
  logic [3:0]          rep_d;

  // Line mode decoded from the live inputs; only sampled on line_start.
  always_comb begin
    bytes_d = wide ? 6'd32 : 6'd16;
    unique case (repeat_sel)
      2'd0:    rep_d = 4'd1;
      2'd1:    rep_d = 4'd2;
      2'd2:    rep_d = 4'd3;
      default: rep_d = 4'd12;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_DONE;
      da_q         <= c_base;
      line_base_q  <= c_base;
      byte_cnt_q   <= '0;
      bytes_q      <= 6'd16;
      rep_q        <= 4'd1;
      rep_cnt_q    <= '0;
      line_cnt_q   <= '0;
      alpha_row_q  <= '0;
      rp_q         <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rp_q         <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (frame_start) begin
        state_q     <= S_WAIT_LINE;
        da_q        <= c_base;
        line_base_q <= c_base;
        byte_cnt_q  <= '0;
        rep_cnt_q   <= '0;
        line_cnt_q  <= '0;
        alpha_row_q <= '0;
        overrun_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_WAIT_LINE: begin
            if (line_start) begin
              bytes_q    <= bytes_d;
              rep_q      <= rep_d;
              da_q       <= line_base_q;
              byte_cnt_q <= '0;
              state_q    <= S_FETCH;
            end
          end
          S_FETCH: begin
            // A premature line_start restarts the line rather than counting it.
            if (line_start) begin
              overrun_q  <= 1'b1;
              bytes_q    <= bytes_d;
              rep_q      <= rep_d;
              da_q       <= line_base_q;
              byte_cnt_q <= '0;
            end else if (fetch) begin
              da_q       <= da_q + ADDR_W'(1);
              byte_cnt_q <= byte_cnt_q + 6'd1;
              if (byte_cnt_q == bytes_q - 6'd1) begin
                state_q <= S_LINE_END;
              end
            end
          end
          S_LINE_END: begin
            line_done_q <= 1'b1;
            line_cnt_q  <= line_cnt_q + c_lc_w'(1);
            // >= covers a smaller repeat factor latched after a larger one.
            if (rep_cnt_q >= rep_q - 4'd1) begin
              rep_cnt_q   <= '0;
              line_base_q <= da_q;
            end else begin
              rep_cnt_q <= rep_cnt_q + 4'd1;
              da_q      <= line_base_q;
            end
            if (alpha_row_q == c_last_row) begin
              alpha_row_q <= '0;
              rp_q        <= 1'b1;
            end else begin
              alpha_row_q <= alpha_row_q + 4'd1;
            end
            if (line_cnt_q == c_last_line) begin
              frame_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_WAIT_LINE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign DA         = da_q;
  assign alpha_row  = alpha_row_q;
  assign rp         = rp_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_video_address_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_address_sequencer
//  Brief    : Randomised bench for video_address_sequencer with a line-level
//             reference model; a second instance exercises address wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_address_sequencer;

  localparam int c_addr_w = 13;
  localparam int c_mask   = (1 << c_addr_w) - 1;
  localparam int c_lines  = 192;
  localparam int c_rows   = 12;
  localparam int c_base_b = 'h1FF0;

  localparam int P_WAIT  = 0;
  localparam int P_FETCH = 1;
  localparam int P_END   = 2;
  localparam int P_DONE  = 3;

  logic                clk = 1'b0;
  logic                reset, frame_start, line_start, fetch, wide;
  logic [1:0]          repeat_sel;
  logic [c_addr_w-1:0] da_a, da_b;
  logic [3:0]          alpha_row_a, alpha_row_b;
  logic                rp_a, line_done_a, frame_done_a, overrun_a;
  logic                rp_b, line_done_b, frame_done_b, overrun_b;

  always #5 clk = ~clk;

  video_address_sequencer u_dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .fetch(fetch), .wide(wide), .repeat_sel(repeat_sel), .DA(da_a),
    .alpha_row(alpha_row_a), .rp(rp_a), .line_done(line_done_a),
    .frame_done(frame_done_a), .overrun(overrun_a)
  );

  video_address_sequencer #(.BASE_ADDR(c_base_b)) u_dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .fetch(fetch), .wide(wide), .repeat_sel(repeat_sel), .DA(da_b),
    .alpha_row(alpha_row_b), .rp(rp_b), .line_done(line_done_b),
    .frame_done(frame_done_b), .overrun(overrun_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cnt_ld, cnt_fd, cnt_rp;

  // Reference model: address offset from base, line progress and pulses.
  int m_phase, m_da, m_group, m_nbytes, m_nrep, m_fetched, m_rep_idx, m_lines;
  bit m_overrun, m_rp, m_ld, m_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_da = 0; m_group = 0; m_fetched = 0; m_rep_idx = 0; m_lines = 0; m_overrun = 0;
  endtask

  task automatic model_begin_line();
    m_nbytes  = wide ? 32 : 16;
    m_nrep    = (repeat_sel == 2'd3) ? 12 : int'(repeat_sel) + 1;
    m_da      = m_group;
    m_fetched = 0;
    m_phase   = P_FETCH;
  endtask

  task automatic model_step();
    m_rp = 0; m_ld = 0; m_fd = 0;
    if (reset) begin
      model_clear();
      m_phase = P_DONE;
    end else if (frame_start) begin
      model_clear();
      m_phase = P_WAIT;
    end else begin
      case (m_phase)
        P_WAIT: if (line_start) model_begin_line();
        P_FETCH: begin
          if (line_start) begin
            m_overrun = 1;
            model_begin_line();
          end else if (fetch) begin
            m_da++;
            m_fetched++;
            if (m_fetched == m_nbytes) m_phase = P_END;
          end
        end
        P_END: begin
          m_ld = 1;
          m_lines++;
          if (m_rep_idx + 1 >= m_nrep) begin
            m_rep_idx = 0;
            m_group   = m_da;
          end else begin
            m_rep_idx++;
            m_da = m_group;
          end
          m_rp = ((m_lines % c_rows) == 0);
          if (m_lines == c_lines) begin
            m_fd    = 1;
            m_phase = P_DONE;
          end else begin
            m_phase = P_WAIT;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("DA", da_a, m_da & c_mask);
    check("DA_wrap_inst", da_b, (m_da + c_base_b) & c_mask);
    check("alpha_row", alpha_row_a, m_lines % c_rows);
    check("rp", rp_a, m_rp);
    check("line_done", line_done_a, m_ld);
    check("frame_done", frame_done_a, m_fd);
    check("overrun", overrun_a, m_overrun);
    if (line_done_a) cnt_ld++;
    if (frame_done_a) cnt_fd++;
    if (rp_a) cnt_rp++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    cnt_ld = 0; cnt_fd = 0; cnt_rp = 0;
  endtask

  task automatic fetch_one(input bit jitter);
    if (jitter) idle($urandom_range(0, 2));
    fetch = 1'b1;
    cycle();
    fetch = 1'b0;
  endtask

  task automatic run_line(input logic w, input logic [1:0] s, input int abort_at, input bit jitter);
    int nb;
    nb = w ? 32 : 16;
    wide = w; repeat_sel = s;
    line_start = 1'b1;
    cycle();
    line_start = 1'b0;
    if (abort_at > 0) begin
      for (int k = 0; k < abort_at; k++) fetch_one(jitter);
      line_start = 1'b1;
      cycle();
      line_start = 1'b0;
    end
    if (jitter) begin
      wide       = 1'($urandom_range(0, 1));
      repeat_sel = 2'($urandom_range(0, 3));
    end
    for (int k = 0; k < nb; k++) fetch_one(jitter);
    cycle();
    if (jitter && $urandom_range(0, 1) == 1) begin
      fetch = 1'b1;
      cycle();
      fetch = 1'b0;
    end
    cycle();
  endtask

  task automatic run_fixed_frame(input logic w, input logic [1:0] s);
    pulse_frame();
    for (int l = 0; l < c_lines; l++) run_line(w, s, 0, 1'b0);
    cycle();
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; fetch = 1'b0;
    wide = 1'b0; repeat_sel = 2'd0;
    cnt_ld = 0; cnt_fd = 0; cnt_rp = 0;
    idle(3);
    reset = 1'b0;
    check("reset_DA", da_a, 0);
    check("reset_DA_b", da_b, c_base_b);
    check("reset_overrun", overrun_a, 0);
    line_start = 1'b1; fetch = 1'b1;
    idle(3);
    line_start = 1'b0; fetch = 1'b0;
    check("done_ignores_DA", da_a, 0);

    run_fixed_frame(1'b1, 2'd0);
    check("t1_DA_end", da_a, 'h1800);
    check("t1_DA_b_end", da_b, ('h1800 + c_base_b) & c_mask);
    check("t1_line_done_cnt", cnt_ld, 192);
    check("t1_frame_done_cnt", cnt_fd, 1);
    check("t1_rp_cnt", cnt_rp, 16);

    run_fixed_frame(1'b0, 2'd2);
    check("t2_DA_end", da_a, 'h400);
    check("t2_line_done_cnt", cnt_ld, 192);

    run_fixed_frame(1'b1, 2'd3);
    check("t3_DA_end", da_a, 'h200);
    check("t3_rp_cnt", cnt_rp, 16);

    pulse_frame();
    run_line(1'b1, 2'd0, 10, 1'b0);
    check("t4_overrun", overrun_a, 1);
    check("t4_one_line_done", cnt_ld, 1);
    check("t4_DA_after_line", da_a, 'h20);
    run_line(1'b1, 2'd0, 0, 1'b0);
    check("t4_overrun_sticky", overrun_a, 1);
    pulse_frame();
    check("t4_overrun_cleared", overrun_a, 0);

    pulse_frame();
    for (int l = 0; l < c_lines; l++) begin
      logic w;
      logic [1:0] s;
      int ab;
      w  = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, w ? 31 : 15)) : 0;
      run_line(w, s, ab, 1'b1);
    end
    cycle();
    check("rand_line_done_cnt", cnt_ld, 192);
    check("rand_frame_done_cnt", cnt_fd, 1);

    pulse_frame();
    run_line(1'b1, 2'd0, 0, 1'b0);
    run_line(1'b1, 2'd0, 0, 1'b0);
    wide = 1'b1; repeat_sel = 2'd0;
    line_start = 1'b1;
    cycle();
    line_start = 1'b0;
    for (int k = 0; k < 5; k++) fetch_one(1'b0);
    check("t6_DA_mid", da_a, 'h45);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6_DA_reset", da_a, 0);
    check("t6_DA_b_reset", da_b, c_base_b);
    line_start = 1'b1;
    cycle();
    line_start = 1'b0;
    fetch = 1'b1;
    idle(4);
    fetch = 1'b0;
    check("t6_DA_ignored", da_a, 0);
    pulse_frame();
    run_line(1'b1, 2'd0, 0, 1'b0);
    check("t6_DA_resume", da_a, 'h20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
